pixel_scan_counter: RTL

PIXEL_SCAN_COUNTER -- requirements
Module: pixel_scan_counter

---
 rtl/scan_pkg.sv | 11 +
 rtl/axis_counter.sv | 21 ++
 rtl/pixel_scan_counter.sv | 71 +++++++
 3 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM state encodings for the pixel scan counter.
package scan_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } scan_state_t;
endpackage

// File: rtl/axis_counter.sv
// axis_counter: one coordinate counter with clear, increment and terminal flag.
module axis_counter #(
   parameter int W     = 9,
   parameter int LIMIT = 320
) (
   input  logic         i_clock,
   input  logic         i_reset_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_count,
   output logic         o_term
);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);
   logic [W-1:0] r_count;
   always_ff @(posedge i_clock)
      if (!i_reset_n) r_count <= '0;
      else if (i_clr) r_count <= '0;
      else if (i_inc) r_count <= r_count + 1'b1;
   assign o_count = r_count;
   assign o_term  = (r_count == LAST);
endmodule

// File: rtl/pixel_scan_counter.sv
// pixel_scan_counter: raster x/y scan with IDLE/RUN/DONE control.
// Define PIXEL_SCAN_ADDR_EN to add a linear pixel address output.
module pixel_scan_counter
   import scan_pkg::*;
#(
   parameter int XW     = 9,
   parameter int YW     = 8,
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int WRAP   = 0
) (
   input  logic          clock,
   input  logic          resetN,
   input  logic          start,
   input  logic          abort,
   input  logic          enable,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          valid,
   output logic          done,
   output logic          busy
`ifdef PIXEL_SCAN_ADDR_EN
   ,
   output logic [$clog2(WIDTH*HEIGHT)-1:0] addr
`endif
);
   localparam logic WRAP_EN = (WRAP != 0);
   scan_state_t r_state, w_state_nxt;
   logic r_done;
   logic w_run, w_step, w_restart, w_last, w_x_term, w_y_term;
   logic w_x_clr, w_y_clr, w_x_inc, w_y_inc;
   assign w_run     = (r_state == S_RUN);
   assign w_restart = abort | start;
   assign w_step    = w_run & enable & ~w_restart;
   assign w_last    = w_x_term & w_y_term;
   assign w_x_inc   = w_step & ~w_x_term;
   assign w_y_inc   = w_step & w_x_term & ~w_y_term;
   // at the final pixel x only clears when the frame wraps; otherwise it holds
   assign w_x_clr   = w_restart | (w_step & w_x_term & (~w_y_term | WRAP_EN));
   assign w_y_clr   = w_restart | (w_step & w_last & WRAP_EN);
   always_comb
      w_state_nxt = abort ? S_IDLE :
                    start ? S_RUN :
                    (w_step & w_last & ~WRAP_EN) ? S_DONE : r_state;
   always_ff @(posedge clock)
      if (!resetN) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_step & w_last;
      end
   axis_counter #(.W(XW), .LIMIT(WIDTH)) u_x (
      .i_clock(clock), .i_reset_n(resetN), .i_clr(w_x_clr), .i_inc(w_x_inc),
      .o_count(x), .o_term(w_x_term)
   );
   axis_counter #(.W(YW), .LIMIT(HEIGHT)) u_y (
      .i_clock(clock), .i_reset_n(resetN), .i_clr(w_y_clr), .i_inc(w_y_inc),
      .o_count(y), .o_term(w_y_term)
   );
`ifdef PIXEL_SCAN_ADDR_EN
   logic [$clog2(WIDTH*HEIGHT)-1:0] r_addr;
   always_ff @(posedge clock)
      if (!resetN || w_y_clr) r_addr <= '0;
      else if (w_x_inc | w_y_inc) r_addr <= r_addr + 1'b1;
   assign addr = r_addr;
`endif
   assign valid = w_run;
   assign busy  = w_run;
   assign done  = r_done;
endmodule
